// File: rtl/core_writeback_arbiter.sv
// core_writeback_arbiter: shares the two register-file write ports among ALU A/B, multiplier and load/store results.
// Define CORE_WB_REFILL_EN to let a holding buffer accept a new result in the cycle it is granted.
module core_writeback_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int REG_W        = 5,
    parameter int DATA_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_a_valid,
    input  logic [REG_W-1:0]        alu_a_rd,
    input  logic [DATA_W-1:0]       alu_a_value,
    input  logic                    alu_b_valid,
    input  logic [REG_W-1:0]        alu_b_rd,
    input  logic [DATA_W-1:0]       alu_b_value,
    input  logic                    mul_valid,
    input  logic [REG_W-1:0]        mul_rd,
    input  logic [DATA_W-1:0]       mul_value,
    output logic                    mul_ready,
    input  logic                    ldst_valid,
    input  logic [REG_W-1:0]        ldst_rd,
    input  logic [DATA_W-1:0]       ldst_value,
    output logic                    ldst_ready,
    output logic                    wr_en_a,
    output logic [REG_W-1:0]        wr_r_a,
    output logic [DATA_W-1:0]       wr_value_a,
    output logic                    wr_en_b,
    output logic [REG_W-1:0]        wr_r_b,
    output logic [DATA_W-1:0]       wr_value_b,
    output logic [(1<<REG_W)-1:0]   pending_mask,
    output logic                    wb_stall
);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG  = 1 << REG_W;

    typedef struct packed {
        logic              en;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
    } wr_t;

    // buffer index 0 is the multiplier, 1 is load/store
    logic [1:0]        off_valid, full, full_next, grant, ready, cap, used;
    logic [REG_W-1:0]  off_rd [2], buf_rd [2], rd_next [2];
    logic [DATA_W-1:0] off_value [2], buf_value [2];
    logic [AGE_W-1:0]  age [2], age_next [2];
    logic              rr, rr_next, a_use, stall_next;
    logic [NREG-1:0]   pend_next;
    wr_t               s_a, s_b, s_mul, s_ldst, port_a, port_b;

    assign off_valid    = {ldst_valid, mul_valid};
    assign off_rd[0]    = mul_rd;
    assign off_rd[1]    = ldst_rd;
    assign off_value[0] = mul_value;
    assign off_value[1] = ldst_value;

`ifdef CORE_WB_REFILL_EN
    assign ready = ~full | grant;
`else
    assign ready = ~full;
`endif
    assign mul_ready  = ready[0];
    assign ldst_ready = ready[1];
    assign cap        = off_valid & ready;

    // same-rd ALU pair: only the younger B result is written
    assign a_use = alu_a_valid && !(alu_b_valid && alu_a_rd == alu_b_rd);
    assign used  = 2'(a_use) + 2'(alu_b_valid);

    always_comb begin
        grant   = 2'b00;
        rr_next = rr;
        if (used == 2'd0)
            grant = full;
        else if (used == 2'd1) begin
            grant   = full == 2'b11 ? (rr ? 2'b10 : 2'b01) : full;
            rr_next = full == 2'b11 ? !rr : rr;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        assign full_next[g] = cap[g] || (full[g] && !grant[g]);
        assign rd_next[g]   = cap[g] ? off_rd[g] : buf_rd[g];
        assign age_next[g]  = cap[g] ? '0
                            : (full[g] && !grant[g] && age[g] != '1) ? age[g] + 1'b1 : age[g];
    end

    always_comb begin
        pend_next  = '0;
        stall_next = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (full_next[i])
                pend_next[rd_next[i]] = 1'b1;
            // a granted entry stays pending through its write cycle
            if (grant[i])
                pend_next[buf_rd[i]] = 1'b1;
            stall_next = stall_next || (full_next[i] && age_next[i] >= AGE_W'(STARVE_LIMIT));
        end
    end

    assign s_a    = {a_use, alu_a_rd, alu_a_value};
    assign s_b    = {alu_b_valid, alu_b_rd, alu_b_value};
    assign s_mul  = {grant[0], buf_rd[0], buf_value[0]};
    assign s_ldst = {grant[1], buf_rd[1], buf_value[1]};
    assign port_a = s_a.en ? s_a : s_b.en ? s_b : s_mul.en ? s_mul : s_ldst;
    assign port_b = s_a.en ? (s_b.en ? s_b : s_mul.en ? s_mul : s_ldst)
                  : s_b.en ? (s_mul.en ? s_mul : s_ldst)
                  : s_mul.en ? s_ldst : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            full         <= '0;
            rr           <= 1'b0;
            wb_stall     <= 1'b0;
            pending_mask <= '0;
            {wr_en_a, wr_r_a, wr_value_a} <= '0;
            {wr_en_b, wr_r_b, wr_value_b} <= '0;
            for (int i = 0; i < 2; i++) begin
                age[i]       <= '0;
                buf_rd[i]    <= '0;
                buf_value[i] <= '0;
            end
        end else begin
            full         <= full_next;
            rr           <= rr_next;
            wb_stall     <= stall_next;
            pending_mask <= pend_next;
            {wr_en_a, wr_r_a, wr_value_a} <= port_a;
            {wr_en_b, wr_r_b, wr_value_b} <= port_b;
            for (int i = 0; i < 2; i++) begin
                age[i] <= age_next[i];
                if (cap[i]) begin
                    buf_rd[i]    <= off_rd[i];
                    buf_value[i] <= off_value[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_core_writeback_arbiter.sv
// tb_core_writeback_arbiter: directed scoreboard bench for core_writeback_arbiter.
module tb_core_writeback_arbiter;
`ifdef CORE_WB_REFILL_EN
    localparam int P = 1;
`else
    localparam int P = 2;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        alu_a_valid, alu_b_valid, mul_valid, ldst_valid;
    logic [4:0]  alu_a_rd, alu_b_rd, mul_rd, ldst_rd, wr_r_a, wr_r_b;
    logic [31:0] alu_a_value, alu_b_value, mul_value, ldst_value, wr_value_a, wr_value_b;
    logic        mul_ready, ldst_ready, wr_en_a, wr_en_b, wb_stall;
    logic [31:0] pending_mask;

    typedef struct {
        int          cyc;
        bit          port;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];
    int   cyc = 0, checks = 0, errors = 0;
    int   c, s;
    bit   mon_en = 1'b0;

    core_writeback_arbiter #(.STARVE_LIMIT(4), .REG_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alu_a_valid(alu_a_valid), .alu_a_rd(alu_a_rd), .alu_a_value(alu_a_value),
        .alu_b_valid(alu_b_valid), .alu_b_rd(alu_b_rd), .alu_b_value(alu_b_value),
        .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_value(mul_value), .mul_ready(mul_ready),
        .ldst_valid(ldst_valid), .ldst_rd(ldst_rd), .ldst_value(ldst_value), .ldst_ready(ldst_ready),
        .wr_en_a(wr_en_a), .wr_r_a(wr_r_a), .wr_value_a(wr_value_a),
        .wr_en_b(wr_en_b), .wr_r_b(wr_r_b), .wr_value_b(wr_value_b),
        .pending_mask(pending_mask), .wb_stall(wb_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_a_valid = 1'b0;
        alu_b_valid = 1'b0;
        mul_valid   = 1'b0;
        ldst_valid  = 1'b0;
    endtask

    task automatic set_alu(input bit a, input int ra, input int va, input bit b, input int rb, input int vb);
        alu_a_valid = a;
        alu_a_rd    = 5'(ra);
        alu_a_value = 32'(va);
        alu_b_valid = b;
        alu_b_rd    = 5'(rb);
        alu_b_value = 32'(vb);
    endtask

    task automatic exp_wr(input int cy, input bit port, input int rd, input int val);
        q.push_back('{cy, port, 5'(rd), 32'(val)});
    endtask

    // monitor: pops this cycle's expected writes and compares both ports
    always @(negedge clk) begin : mon
        logic        ea, eb;
        logic [4:0]  ra, rb;
        logic [31:0] va, vb;
        if (mon_en) begin
            ea = 1'b0; eb = 1'b0; ra = '0; rb = '0; va = '0; vb = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc <= cyc) begin
                    if (q[i].port) begin
                        eb = 1'b1; rb = q[i].rd; vb = q[i].val;
                    end else begin
                        ea = 1'b1; ra = q[i].rd; va = q[i].val;
                    end
                    q.delete(i);
                end
            end
            if (ea || wr_en_a)
                chk("port_a", 64'({wr_en_a, wr_r_a, wr_value_a}), 64'({ea, ra, va}));
            if (eb || wr_en_b)
                chk("port_b", 64'({wr_en_b, wr_r_b, wr_value_b}), 64'({eb, rb, vb}));
            if (!rst && alu_a_valid)
                chk("waw_a", 64'(pending_mask[alu_a_rd]), 64'(0));
            if (!rst && alu_b_valid)
                chk("waw_b", 64'(pending_mask[alu_b_rd]), 64'(0));
        end
    end

    initial begin
        idle();
        set_alu(0, 0, 0, 0, 0, 0);
        ldst_rd = '0; ldst_value = '0;
        mul_valid = 1'b1; mul_rd = 5'd30; mul_value = 32'hBAD;
        repeat (2) tick();
        rst = 1'b0;
        idle();
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_wr_en", 64'({wr_en_a, wr_en_b}), 64'(0));
        chk("rst_stall", 64'(wb_stall), 64'(0));
        chk("rst_pending", 64'(pending_mask), 64'(0));
        chk("rst_ready", 64'({mul_ready, ldst_ready}), 64'(2'b11));

        tick();
        chk("drop_pending", 64'(pending_mask), 64'(0));
        set_alu(1, 3, 'h11, 1, 5, 'h22);
        exp_wr(cyc + 1, 0, 3, 'h11);
        exp_wr(cyc + 1, 1, 5, 'h22);
        tick();
        set_alu(1, 7, 'h33, 1, 7, 'h44);
        exp_wr(cyc + 1, 0, 7, 'h44);
        tick();
        idle();
        repeat (2) tick();

        mul_valid = 1'b1; mul_rd = 5'd9; mul_value = 32'hDEAD;
        exp_wr(cyc + 2, 0, 9, 'hDEAD);
        @(negedge clk);
        chk("mul_ready_idle", 64'(mul_ready), 64'(1));
        tick();
        mul_valid = 1'b0;
        @(negedge clk);
        chk("pend_hold", 64'(pending_mask), 64'(32'h200));
        chk("mul_busy", 64'(mul_ready), 64'(P == 1));
        tick();
        @(negedge clk);
        chk("pend_write", 64'(pending_mask), 64'(32'h200));
        chk("mul_free", 64'(mul_ready), 64'(1));
        tick();
        @(negedge clk);
        chk("pend_clear", 64'(pending_mask), 64'(0));
        tick();

        c = cyc;
        set_alu(1, 1, 1, 1, 2, 2);
        mul_valid = 1'b1; mul_rd = 5'd10; mul_value = 32'hA0;
        ldst_valid = 1'b1; ldst_rd = 5'd11; ldst_value = 32'hB0;
        exp_wr(c + 1, 0, 1, 1); exp_wr(c + 1, 1, 2, 2);
        tick();
        idle();
        set_alu(1, 3, 3, 1, 4, 4);
        exp_wr(c + 2, 0, 3, 3); exp_wr(c + 2, 1, 4, 4);
        @(negedge clk);
        chk("rr_pend", 64'(pending_mask), 64'(32'h0C00));
        tick();
        set_alu(1, 5, 5, 0, 0, 0);
        exp_wr(c + 3, 0, 5, 5); exp_wr(c + 3, 1, 10, 'hA0);
        tick();
        set_alu(1, 6, 6, 1, 7, 7);
        mul_valid = 1'b1; mul_rd = 5'd12; mul_value = 32'hA2;
        exp_wr(c + 4, 0, 6, 6); exp_wr(c + 4, 1, 7, 7);
        @(negedge clk);
        chk("rr_mul_ready", 64'(mul_ready), 64'(1));
        tick();
        mul_valid = 1'b0;
        set_alu(1, 8, 8, 0, 0, 0);
        exp_wr(c + 5, 0, 8, 8); exp_wr(c + 5, 1, 11, 'hB0);
        tick();
        set_alu(1, 14, 14, 1, 15, 15);
        ldst_valid = 1'b1; ldst_rd = 5'd13; ldst_value = 32'hB1;
        exp_wr(c + 6, 0, 14, 14); exp_wr(c + 6, 1, 15, 15);
        @(negedge clk);
        chk("rr_ldst_ready", 64'(ldst_ready), 64'(1));
        tick();
        ldst_valid = 1'b0;
        set_alu(1, 16, 16, 0, 0, 0);
        exp_wr(c + 7, 0, 16, 16); exp_wr(c + 7, 1, 12, 'hA2);
        tick();
        idle();
        exp_wr(c + 8, 0, 13, 'hB1);
        tick();
        @(negedge clk);
        chk("rr_no_stall", 64'(wb_stall), 64'(0));
        repeat (2) tick();

        s = cyc;
        mul_valid = 1'b1; mul_rd = 5'd20; mul_value = 32'h5555;
        for (int i = 0; i <= 5; i++) begin
            set_alu(1, 1, 'h100 + i, 1, 2, 'h200 + i);
            exp_wr(cyc + 1, 0, 1, 'h100 + i);
            exp_wr(cyc + 1, 1, 2, 'h200 + i);
            @(negedge clk);
            if (i == 4) chk("stall_pre", 64'(wb_stall), 64'(0));
            if (i == 5) chk("stall_rise", 64'(wb_stall), 64'(1));
            tick();
            mul_valid = 1'b0;
        end
        idle();
        exp_wr(s + 7, 0, 20, 'h5555);
        @(negedge clk);
        chk("stall_hold", 64'(wb_stall), 64'(1));
        tick();
        @(negedge clk);
        chk("stall_drop", 64'(wb_stall), 64'(0));
        repeat (2) tick();

        for (int j = 0; j < 4 * P; j++) begin
            mul_valid = 1'b1;
            mul_rd    = 5'(21 + j / P);
            mul_value = 32'('h100 + j / P);
            if (j % P == 0) exp_wr(cyc + 2, 0, 21 + j / P, 'h100 + j / P);
            @(negedge clk);
            chk("refill_ready", 64'(mul_ready), 64'(j % P == 0));
            tick();
        end
        idle();
        repeat (4) tick();

        mul_valid = 1'b1; mul_rd = 5'd25; mul_value = 32'h25;
        ldst_valid = 1'b1; ldst_rd = 5'd26; ldst_value = 32'h26;
        for (int i = 0; i <= 5; i++) begin
            set_alu(1, 1, 'h300 + i, 1, 2, 'h400 + i);
            exp_wr(cyc + 1, 0, 1, 'h300 + i);
            exp_wr(cyc + 1, 1, 2, 'h400 + i);
            @(negedge clk);
            if (i == 5) chk("stall_before_rst", 64'(wb_stall), 64'(1));
            tick();
            mul_valid = 1'b0;
            ldst_valid = 1'b0;
        end
        rst = 1'b1;
        set_alu(1, 1, 'h555, 1, 2, 'h666);
        mul_valid = 1'b1; mul_rd = 5'd27; mul_value = 32'h27;
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("mid_rst_wr_en", 64'({wr_en_a, wr_en_b}), 64'(0));
        chk("mid_rst_stall", 64'(wb_stall), 64'(0));
        chk("mid_rst_pending", 64'(pending_mask), 64'(0));
        chk("mid_rst_ready", 64'({mul_ready, ldst_ready}), 64'(2'b11));
        repeat (4) tick();

        chk("sb_drain", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
